fft_capture_ctrl: RTL and testbench

Write-side sequencer between the FFT core output and the 32-bit-in / 8-bit-out dual-clock output FIFO that feeds the USB interface. It discards a programmable number of settling samples after arming. It then aligns to FFT frame boundaries and writes whole frames of packed {re, im} words into the FIFO. It also detects FIFO overflow and frame misalignment, and counts completed frames for status readout.

---
 rtl/fft_io_pkg.sv | 22 ++
 rtl/fft_capture_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fft_capture_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_io_pkg.sv
// Shared types for the FFT output path: capture FSM states,
// sample/word widths and the {re, im} word packing helper.
package fft_io_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT_SOF,
    ST_CAPTURE
  } cap_state_e;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [SAMPLE_W-1:0] re,
    input logic [SAMPLE_W-1:0] im
  );
    return {re, im};
  endfunction

endpackage

// File: rtl/fft_capture_ctrl.sv
// Write-side sequencer from the FFT core output into the USB FIFO.
// Ports: CLK/reset (sync, active-low); arm/abort/continuous control;
//   fft_valid/fft_sof/fft_re/fft_im sample stream in;
//   fifo_din/fifo_wr_en/fifo_full FIFO write side;
//   busy/frame_done/overflow/sync_err/frame_count status out.
module fft_capture_ctrl
  import fft_io_pkg::*;
#(
  parameter int FRAME_LEN      = 1024,
  parameter int SETTLE_SAMPLES = 1025,
  parameter int FCNT_W         = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                arm,
  input  logic                abort,
  input  logic                continuous,
  input  logic                fft_valid,
  input  logic                fft_sof,
  input  logic [SAMPLE_W-1:0] fft_re,
  input  logic [SAMPLE_W-1:0] fft_im,
  output logic [WORD_W-1:0]   fifo_din,
  output logic                fifo_wr_en,
  input  logic                fifo_full,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow,
  output logic                sync_err,
  output logic [FCNT_W-1:0]   frame_count
);

  // One counter serves both the settle phase and the frame phase.
  localparam int CMAX  = (FRAME_LEN > SETTLE_SAMPLES) ?
                         FRAME_LEN : SETTLE_SAMPLES;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] FRM_LAST =
    CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SET_LAST =
    (SETTLE_SAMPLES == 0) ? '0 : CNT_W'(SETTLE_SAMPLES - 1);

  cap_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cont_q, cont_d;
  logic [WORD_W-1:0]   din_q, din_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                serr_q, serr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  // State after a frame ends or is dropped.
  cap_state_e          after_q;
  assign after_q = cont_q ? ST_WAIT_SOF : ST_IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    din_d   = din_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    serr_d  = serr_q;
    fcnt_d  = fcnt_q;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            cont_d  = continuous;
            ovf_d   = 1'b0;
            serr_d  = 1'b0;
            fcnt_d  = '0;
            cnt_d   = '0;
            state_d = (SETTLE_SAMPLES == 0) ?
                      ST_WAIT_SOF : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (fft_valid) begin
            if (cnt_q == SET_LAST) begin
              cnt_d   = '0;
              state_d = ST_WAIT_SOF;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_WAIT_SOF: begin
          if (fft_valid && fft_sof) begin
            if (fifo_full) begin
              ovf_d   = 1'b1;
              state_d = after_q;
            end else begin
              wr_d    = 1'b1;
              din_d   = pack_word(fft_re, fft_im);
              cnt_d   = CNT_W'(1);
              state_d = ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (fft_valid) begin
            if (fifo_full) begin
              // Partial frame is abandoned; written words stay.
              ovf_d   = 1'b1;
              cnt_d   = '0;
              state_d = after_q;
            end else begin
              wr_d  = 1'b1;
              din_d = pack_word(fft_re, fft_im);
              if (fft_sof) begin
                serr_d = 1'b1;
                cnt_d  = CNT_W'(1);
              end else if (cnt_q == FRM_LAST) begin
                done_d  = 1'b1;
                fcnt_d  = fcnt_q + 1'b1;
                cnt_d   = '0;
                state_d = after_q;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign fifo_din    = din_q;
  assign fifo_wr_en  = wr_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = done_q;
  assign overflow    = ovf_q;
  assign sync_err    = serr_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_fft_capture_ctrl.sv
// Directed bench for fft_capture_ctrl: FRAME_LEN=8, SETTLE_SAMPLES=4,
// plus a SETTLE_SAMPLES=0 instance for the no-settle edge case.
module tb_fft_capture_ctrl;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic        fft_valid = 1'b0;
  logic        fft_sof = 1'b0;
  logic [15:0] fft_re = '0;
  logic [15:0] fft_im = '0;
  logic        fifo_full = 1'b0;

  logic [31:0] fifo_din, din0;
  logic        fifo_wr_en, wr0;
  logic        busy, busy0;
  logic        frame_done, done0;
  logic        overflow, ovf0;
  logic        sync_err, serr0;
  logic [15:0] frame_count, fcnt0;

  fft_capture_ctrl #(
    .FRAME_LEN(8), .SETTLE_SAMPLES(4), .FCNT_W(16)
  ) u_dut (
    .CLK(CLK), .reset(reset), .arm(arm), .abort(abort),
    .continuous(continuous), .fft_valid(fft_valid),
    .fft_sof(fft_sof), .fft_re(fft_re), .fft_im(fft_im),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .busy(busy),
    .frame_done(frame_done), .overflow(overflow),
    .sync_err(sync_err), .frame_count(frame_count)
  );

  fft_capture_ctrl #(
    .FRAME_LEN(8), .SETTLE_SAMPLES(0), .FCNT_W(16)
  ) u_dut0 (
    .CLK(CLK), .reset(reset), .arm(arm), .abort(abort),
    .continuous(continuous), .fft_valid(fft_valid),
    .fft_sof(fft_sof), .fft_re(fft_re), .fft_im(fft_im),
    .fifo_din(din0), .fifo_wr_en(wr0),
    .fifo_full(fifo_full), .busy(busy0),
    .frame_done(done0), .overflow(ovf0),
    .sync_err(serr0), .frame_count(fcnt0)
  );

  always #5 CLK = ~CLK;

  logic [31:0] wq[$];
  int          n_done = 0;

  always @(negedge CLK) begin
    if (fifo_wr_en) wq.push_back(fifo_din);
    if (frame_done) n_done++;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int wbase, dbase;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic s,
                       input logic [15:0] re,
                       input logic [15:0] im);
    fft_valid = v;
    fft_sof   = s;
    fft_re    = re;
    fft_im    = im;
    cyc();
  endtask

  task automatic do_arm(input logic c);
    arm = 1'b1;
    continuous = c;
    cyc();
    arm = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'hEEEE, 16'h0);
  endtask

  task automatic mark();
    wbase = wq.size();
    dbase = n_done;
  endtask

  task automatic idle(input int n);
    fft_valid = 1'b0;
    fft_sof   = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_din", fifo_din, 32'h0);
    chk("rst_wr", fifo_wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fcnt", frame_count, 16'd0);
    chk("rst_flags", {overflow, sync_err, frame_done}, 3'b000);
    reset = 1'b1;
    cyc();

    // Single frame, sof on 5th valid
    mark();
    do_arm(1'b0);
    chk("single_busy", busy, 1'b1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i == 4, 16'(i), 16'(-i));
      if (i == 11) begin
        chk("single_done", frame_done, 1'b1);
        chk("single_fcnt", frame_count, 16'd1);
        chk("single_busy_fall", busy, 1'b0);
      end
    end
    idle(2);
    chk("single_words", wq.size() - wbase, 8);
    chk("single_w0", wq[wbase], 32'h0004FFFC);
    chk("single_w7", wq[wbase+7], 32'h000BFFF5);
    chk("single_ndone", n_done - dbase, 1);

    // Continuous: 3 frames then abort 3 samples into the 4th
    mark();
    do_arm(1'b1);
    settle();
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 8; j++) begin
        if (f < 3 || j < 3)
          drive(1'b1, j == 0, 16'(f*8 + j), 16'h0);
      end
    end
    abort = 1'b1;
    drive(1'b1, 1'b0, 16'h00FF, 16'h0);
    abort = 1'b0;
    chk("cont_abort_idle", busy, 1'b0);
    chk("cont_abort_nowr", fifo_wr_en, 1'b0);
    idle(2);
    chk("cont_words", wq.size() - wbase, 27);
    chk("cont_fcnt", frame_count, 16'd3);
    chk("cont_ndone", n_done - dbase, 3);
    chk("cont_w8", wq[wbase+8], 32'h00080000);
    chk("cont_w26", wq[wbase+26], 32'h001A0000);

    // Overflow on 3rd sample, then a clean frame
    mark();
    do_arm(1'b1);
    settle();
    drive(1'b1, 1'b1, 16'h0010, 16'h0);
    drive(1'b1, 1'b0, 16'h0011, 16'h0);
    fifo_full = 1'b1;
    drive(1'b1, 1'b0, 16'h0012, 16'h0);
    fifo_full = 1'b0;
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_nowr", fifo_wr_en, 1'b0);
    chk("ovf_busy", busy, 1'b1);
    for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, 16'h0013, 16'h0);
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, j == 0, 16'(32 + j), 16'h0);
      if (j == 7) begin
        chk("ovf_done", frame_done, 1'b1);
        chk("ovf_fcnt", frame_count, 16'd1);
      end
    end
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    idle(1);
    chk("ovf_words", wq.size() - wbase, 10);
    chk("ovf_w1", wq[wbase+1], 32'h00110000);
    chk("ovf_w2", wq[wbase+2], 32'h00200000);
    chk("ovf_ndone", n_done - dbase, 1);
    chk("ovf_sticky", overflow, 1'b1);

    // Misaligned sof at sample 5
    mark();
    do_arm(1'b0);
    chk("arm_clr_ovf", overflow, 1'b0);
    settle();
    for (int j = 0; j < 4; j++)
      drive(1'b1, j == 0, 16'(48 + j), 16'h0);
    drive(1'b1, 1'b1, 16'h0040, 16'h0);
    chk("sync_flag", sync_err, 1'b1);
    chk("sync_wr", fifo_wr_en, 1'b1);
    for (int j = 0; j < 7; j++) begin
      drive(1'b1, 1'b0, 16'(65 + j), 16'h0);
      if (j == 6) begin
        chk("sync_done", frame_done, 1'b1);
        chk("sync_fcnt", frame_count, 16'd1);
      end
    end
    idle(2);
    chk("sync_words", wq.size() - wbase, 12);
    chk("sync_w4", wq[wbase+4], 32'h00400000);
    chk("sync_ndone", n_done - dbase, 1);
    chk("sync_idle", busy, 1'b0);

    // Reset mid-capture
    do_arm(1'b1);
    settle();
    drive(1'b1, 1'b1, 16'h0070, 16'h0);
    drive(1'b1, 1'b0, 16'h0071, 16'h0);
    drive(1'b1, 1'b0, 16'h0072, 16'h0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'h0073, 16'h0);
    reset = 1'b1;
    chk("rstm_out", {fifo_wr_en, busy, frame_done,
                     overflow, sync_err}, 5'b0);
    chk("rstm_din", fifo_din, 32'h0);
    chk("rstm_fcnt", frame_count, 16'd0);
    mark();
    for (int j = 0; j < 10; j++)
      drive(1'b1, j == 0 || j == 8, 16'(j), 16'h0);
    idle(2);
    chk("rstm_nowr", wq.size() - wbase, 0);
    chk("rstm_idle", busy, 1'b0);

    // SETTLE_SAMPLES=0: arm then sof in next cycle
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    do_arm(1'b0);
    chk("s0_busy", busy0, 1'b1);
    chk("s0_nowr", wr0, 1'b0);
    drive(1'b1, 1'b1, 16'h0055, 16'h0066);
    chk("s0_wr", wr0, 1'b1);
    chk("s0_din", din0, 32'h00550066);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    chk("s0_abort", busy0, 1'b0);

    // arm and abort together
    arm = 1'b1;
    abort = 1'b1;
    cyc();
    arm = 1'b0;
    abort = 1'b0;
    chk("armabort", busy, 1'b0);
    chk("armabort0", busy0, 1'b0);
    cyc();
    chk("armabort_hold", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
